mem_port_sched: RTL and testbench

Sequencer that shares the single unified memory port between the instruction-fetch requester and the data-access requester of the MIPS core. It grants one requester at a time and holds the latched address and write data stable for a fixed multi-cycle memory latency. It pulses the requester's ready signal with captured read data, and produces the core stall signal. It sits between the core datapath/cache controllers and the external memory model.

---
 rtl/mem_port_sched_if.sv | 33 +++
 rtl/mem_port_sched.sv | 205 ++++++++++++++++++++
 tb/tb_mem_port_sched.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_sched_if.sv
// Signal bundle between the MIPS core requesters, mem_port_sched and the external memory.
// The core/memory side uses the master modport; the scheduler uses slave.
interface mem_port_sched_if #(
    parameter int XLEN = 32
);
  logic             if_req;
  logic [XLEN-1:0]  if_addr;
  logic [XLEN-1:0]  if_rdata;
  logic             if_ready;
  logic             d_req;
  logic             d_we;
  logic [XLEN-1:0]  d_addr;
  logic [3:0][7:0]  d_wdata;
  logic [3:0][7:0]  d_rdata;
  logic             d_ready;
  logic [XLEN-1:0]  mem_addr;
  logic [3:0][7:0]  mem_data_in;
  logic [3:0][7:0]  mem_data_out;
  logic             mem_write_en;
  logic             stall;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_addr, mem_data_in,
           mem_write_en, stall
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    output if_rdata, if_ready, d_rdata, d_ready, mem_addr, mem_data_in,
           mem_write_en, stall
  );
endinterface

// File: rtl/mem_port_sched.sv
// Shares one multi-cycle memory port between instruction fetch and data access.
// Define MEM_SCHED_RR_EN for round-robin on contention; otherwise data always wins.
module mem_port_sched #(
  parameter int XLEN        = 32,
  parameter int MEM_LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            halted,
  mem_port_sched_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic       OWN_FETCH = 1'b0;
  localparam logic       OWN_DATA  = 1'b1;
  localparam logic [3:0] CNT_INIT  = 4'(MEM_LATENCY - 1);

  state_t            state_r;
  state_t            state_s;
  logic              owner_r;
  logic              owner_s;
  logic              is_write_r;
  logic              is_write_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_s;
  logic [XLEN-1:0]   addr_r;
  logic [XLEN-1:0]   addr_s;
  logic [3:0][7:0]   wdata_r;
  logic [3:0][7:0]   wdata_s;

  logic              grant_s;
  logic              grant_data_s;
  logic              capture_s;
  logic              we_s;
  logic              if_ready_s;
  logic              d_ready_s;

  logic              we_r;
  logic              if_ready_r;
  logic              d_ready_r;
  logic [3:0][7:0]   if_word_r;
  logic [3:0][7:0]   d_word_r;

`ifdef MEM_SCHED_RR_EN
  logic              last_grant_r;
`endif

  // Arbitration between pending requests; only IDLE and not halted may grant.
  always_comb begin
    grant_s      = 1'b0;
    grant_data_s = 1'b0;
    if ((state_r == ST_IDLE) && !halted) begin
      if (bus.d_req && bus.if_req) begin
        grant_s = 1'b1;
`ifdef MEM_SCHED_RR_EN
        grant_data_s = (last_grant_r == OWN_FETCH);
`else
        grant_data_s = 1'b1;
`endif
      end else if (bus.d_req) begin
        grant_s      = 1'b1;
        grant_data_s = 1'b1;
      end else if (bus.if_req) begin
        grant_s      = 1'b1;
        grant_data_s = 1'b0;
      end else begin
        grant_s      = 1'b0;
        grant_data_s = 1'b0;
      end
    end else begin
      grant_s      = 1'b0;
      grant_data_s = 1'b0;
    end
  end

  // Next-state and access-context logic.
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    is_write_s = is_write_r;
    cnt_s      = cnt_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_s    = ST_BUSY;
          owner_s    = grant_data_s ? OWN_DATA : OWN_FETCH;
          is_write_s = grant_data_s & bus.d_we;
          cnt_s      = CNT_INIT;
          addr_s     = grant_data_s ? bus.d_addr : bus.if_addr;
          wdata_s    = bus.d_wdata;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_DONE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Output decode: next-cycle values for the registered strobes and pulses.
  always_comb begin
    capture_s  = (state_r == ST_BUSY) && (cnt_r == 4'd0) && !is_write_r;
    we_s       = (state_s == ST_BUSY) && (cnt_s == 4'd0) && is_write_s;
    if_ready_s = (state_r == ST_BUSY) && (cnt_r == 4'd0) && (owner_r == OWN_FETCH);
    d_ready_s  = (state_r == ST_BUSY) && (cnt_r == 4'd0) && (owner_r == OWN_DATA);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latched access context held stable on the memory port.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      owner_r    <= OWN_FETCH;
      is_write_r <= 1'b0;
      cnt_r      <= 4'd0;
      addr_r     <= {XLEN{1'b0}};
      wdata_r    <= 32'h0000_0000;
    end else begin
      owner_r    <= owner_s;
      is_write_r <= is_write_s;
      cnt_r      <= cnt_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
    end
  end

  // Registered write strobe and completion pulses; reset drops them at once.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      we_r       <= 1'b0;
      if_ready_r <= 1'b0;
      d_ready_r  <= 1'b0;
    end else begin
      we_r       <= we_s;
      if_ready_r <= if_ready_s;
      d_ready_r  <= d_ready_s;
    end
  end

  // Read data lands in the owner's holding register; stores leave both untouched.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      if_word_r <= 32'h0000_0000;
      d_word_r  <= 32'h0000_0000;
    end else if (capture_s) begin
      if (owner_r == OWN_DATA) begin
        d_word_r <= bus.mem_data_out;
      end else begin
        if_word_r <= bus.mem_data_out;
      end
    end else begin
      if_word_r <= if_word_r;
      d_word_r  <= d_word_r;
    end
  end

`ifdef MEM_SCHED_RR_EN
  // Remember the most recent winner for round-robin contention.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      last_grant_r <= OWN_FETCH;
    end else if (grant_s) begin
      last_grant_r <= grant_data_s ? OWN_DATA : OWN_FETCH;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  assign bus.mem_addr     = addr_r;
  assign bus.mem_data_in  = wdata_r;
  assign bus.mem_write_en = we_r;
  assign bus.if_ready     = if_ready_r;
  assign bus.d_ready      = d_ready_r;
  assign bus.if_rdata     = {if_word_r[3], if_word_r[2], if_word_r[1], if_word_r[0]};
  assign bus.d_rdata      = d_word_r;
  assign bus.stall        = (bus.if_req & ~if_ready_r) | (bus.d_req & ~d_ready_r);

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed self-checking bench for mem_port_sched with MEM_LATENCY=4 and a small memory model.
module tb_mem_port_sched;

  logic clk;
  logic rst_b;
  logic halted;
  int   checks;
  int   errors;

`ifdef MEM_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  mem_port_sched_if #(.XLEN(32)) bus ();

  mem_port_sched #(.XLEN(32), .MEM_LATENCY(4)) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .halted (halted),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory; address 0x40 is a fixed instruction word.
  logic [31:0] mem [0:255] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.mem_write_en) mem[bus.mem_addr[9:2]] <= bus.mem_data_in;
  end
  assign bus.mem_data_out = (bus.mem_addr[9:2] == 8'h10) ? 32'h2408_000A : mem[bus.mem_addr[9:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_b = 1'b0;
    halted = 1'b0;
    bus.if_req = 1'b0;
    bus.if_addr = 32'h0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h0;
    bus.d_wdata = 32'h0;

    // Reset state
    next_cycle();
    next_cycle();
    chk("rst mem_addr", bus.mem_addr, 32'h0);
    chk("rst mem_data_in", bus.mem_data_in, 32'h0);
    chk("rst mem_write_en", 32'(bus.mem_write_en), 32'h0);
    chk("rst if_ready", 32'(bus.if_ready), 32'h0);
    chk("rst d_ready", 32'(bus.d_ready), 32'h0);
    chk("rst if_rdata", bus.if_rdata, 32'h0);
    chk("rst d_rdata", bus.d_rdata, 32'h0);
    chk("rst stall", 32'(bus.stall), 32'h0);
    rst_b = 1'b1;
    next_cycle();

    // Fetch only
    bus.if_addr = 32'h40;
    bus.if_req = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      #1;
      chk($sformatf("t1 if_ready c%0d", c), 32'(bus.if_ready), 32'(c == 5));
      chk($sformatf("t1 stall c%0d", c), 32'(bus.stall), 32'(c <= 4));
      chk($sformatf("t1 we c%0d", c), 32'(bus.mem_write_en), 32'h0);
      if (c >= 1 && c <= 4) chk($sformatf("t1 mem_addr c%0d", c), bus.mem_addr, 32'h40);
      if (c == 5) begin
        chk("t1 if_rdata", bus.if_rdata, 32'h2408_000A);
        bus.if_req = 1'b0;
      end
      next_cycle();
    end

    // Store then load of the same address
    bus.d_addr = 32'h100;
    bus.d_wdata = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    bus.d_we = 1'b1;
    bus.d_req = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      #1;
      chk($sformatf("t2 we c%0d", c), 32'(bus.mem_write_en), 32'(c == 4));
      chk($sformatf("t2 d_ready c%0d", c), 32'(bus.d_ready), 32'(c == 5));
      chk($sformatf("t2 if_ready c%0d", c), 32'(bus.if_ready), 32'h0);
      if (c == 4) begin
        chk("t2 mem_addr", bus.mem_addr, 32'h100);
        chk("t2 mem_data_in", bus.mem_data_in, 32'hDDCC_BBAA);
      end
      if (c == 5) begin
        chk("t2 d_rdata unchanged", bus.d_rdata, 32'h0);
        bus.d_req = 1'b0;
      end
      next_cycle();
    end
    chk("t2 mem word", mem[8'h40], 32'hDDCC_BBAA);
    bus.d_we = 1'b0;
    bus.d_req = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      #1;
      chk($sformatf("t2l d_ready c%0d", c), 32'(bus.d_ready), 32'(c == 5));
      chk($sformatf("t2l we c%0d", c), 32'(bus.mem_write_en), 32'h0);
      if (c == 5) begin
        chk("t2l d_rdata", bus.d_rdata, 32'hDDCC_BBAA);
        chk("t2l d_rdata byte0", 32'(bus.d_rdata[0]), 32'hAA);
        bus.d_req = 1'b0;
      end
      next_cycle();
    end

    // Reset in the write cycle of a store aborts it
    bus.d_addr = 32'h104;
    bus.d_wdata = 32'h1122_3344;
    bus.d_we = 1'b1;
    bus.d_req = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      #1;
      chk($sformatf("t5 we c%0d", c), 32'(bus.mem_write_en), 32'(c == 4));
      if (c < 4) next_cycle();
    end
    rst_b = 1'b0;
    #1;
    chk("t5 we after rst", 32'(bus.mem_write_en), 32'h0);
    chk("t5 mem_addr after rst", bus.mem_addr, 32'h0);
    chk("t5 mem_data_in after rst", bus.mem_data_in, 32'h0);
    chk("t5 d_rdata after rst", bus.d_rdata, 32'h0);
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    next_cycle();
    next_cycle();
    rst_b = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      #1;
      chk($sformatf("t5 d_ready c%0d", c), 32'(bus.d_ready), 32'h0);
      chk($sformatf("t5 we post c%0d", c), 32'(bus.mem_write_en), 32'h0);
      chk($sformatf("t5 mem_addr post c%0d", c), bus.mem_addr, 32'h0);
      chk($sformatf("t5 stall post c%0d", c), 32'(bus.stall), 32'h0);
      next_cycle();
    end
    chk("t5 mem word untouched", mem[8'h41], 32'h0);

    // Contention: data first, then fetch
    bus.if_addr = 32'h40;
    bus.d_addr = 32'h100;
    bus.d_we = 1'b0;
    bus.if_req = 1'b1;
    bus.d_req = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      #1;
      chk($sformatf("t3 d_ready c%0d", c), 32'(bus.d_ready), 32'(c == 5));
      chk($sformatf("t3 if_ready c%0d", c), 32'(bus.if_ready), 32'(c == 11));
      if (c >= 1 && c <= 4) chk($sformatf("t3 mem_addr c%0d", c), bus.mem_addr, 32'h100);
      if (c >= 7 && c <= 10) chk($sformatf("t3 mem_addr c%0d", c), bus.mem_addr, 32'h40);
      if (c == 5) begin
        chk("t3 d_rdata", bus.d_rdata, 32'hDDCC_BBAA);
        bus.d_req = 1'b0;
      end
      if (c == 11) begin
        chk("t3 if_rdata", bus.if_rdata, 32'h2408_000A);
        bus.if_req = 1'b0;
      end
      next_cycle();
    end

    // Both requests held for four transfers
    bus.if_req = 1'b1;
    bus.d_req = 1'b1;
    for (int c = 0; c <= 23; c++) begin
      #1;
      chk($sformatf("t4 d_ready c%0d", c), 32'(bus.d_ready),
          32'((c % 6 == 5) && (!RR || ((c / 6) % 2 == 0))));
      chk($sformatf("t4 if_ready c%0d", c), 32'(bus.if_ready),
          32'((c % 6 == 5) && RR && ((c / 6) % 2 == 1)));
      if (c == 23) begin
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
      end
      next_cycle();
    end
    #1;
    chk("t4 idle d_ready", 32'(bus.d_ready), 32'h0);
    chk("t4 idle if_ready", 32'(bus.if_ready), 32'h0);
    next_cycle();

    // Halt during a fetch blocks the pending data request
    bus.if_addr = 32'h40;
    bus.if_req = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      #1;
      if (c == 2) begin
        halted = 1'b1;
        bus.d_addr = 32'h100;
        bus.d_we = 1'b0;
        bus.d_req = 1'b1;
        #1;
      end
      chk($sformatf("t6 if_ready c%0d", c), 32'(bus.if_ready), 32'(c == 5));
      chk($sformatf("t6 d_ready c%0d", c), 32'(bus.d_ready), 32'(c == 19));
      chk($sformatf("t6 we c%0d", c), 32'(bus.mem_write_en), 32'h0);
      if (c == 10 || c == 14) begin
        chk($sformatf("t6 mem_addr c%0d", c), bus.mem_addr, 32'h40);
        chk($sformatf("t6 stall c%0d", c), 32'(bus.stall), 32'h1);
      end
      if (c >= 15 && c <= 18) chk($sformatf("t6 mem_addr c%0d", c), bus.mem_addr, 32'h100);
      if (c == 5) bus.if_req = 1'b0;
      if (c == 14) halted = 1'b0;
      if (c == 19) begin
        chk("t6 d_rdata", bus.d_rdata, 32'hDDCC_BBAA);
        bus.d_req = 1'b0;
      end
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
